// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the MIPS load/store to Avalon-MM initiator.
package mem_access_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Only the low two address bits can make an access misaligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr[0];
      SZ_WORD: bad = (addr != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane mapping: byteenable and store-data replication on the way out,
// lane extraction and sign/zero extension of load data on the way back.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  output logic [31:0] rdata_ext
);

  logic [15:0] lane_lo;

  always_comb begin
    lane_lo    = 16'(rdata >> {offset, 3'b000});
    byteenable = 4'b0000;
    writedata  = 32'h0;
    rdata_ext  = 32'h0;
    case (size)
      SZ_BYTE: begin
        byteenable = 4'b0001 << offset;
        writedata  = {4{wdata[7:0]}};
        rdata_ext  = {{24{sign_ext & lane_lo[7]}}, lane_lo[7:0]};
      end
      SZ_HALF: begin
        byteenable = 4'b0011 << offset;
        writedata  = {2{wdata[15:0]}};
        rdata_ext  = {{16{sign_ext & lane_lo[15]}}, lane_lo};
      end
      SZ_WORD: begin
        byteenable = 4'b1111;
        writedata  = wdata;
        rdata_ext  = rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_master.sv
// Avalon-MM initiator for CPU loads/stores: one outstanding access at a time,
// misaligned or reserved-size requests answered with an error and no bus cycle.
//
// state  | meaning
// IDLE   | req_ready high, waiting for a CPU request
// ACCESS | read/write strobe on the bus, held through waitrequest
// RESP   | one-cycle resp_valid pulse, then back to IDLE
module mem_access_master
  import mem_access_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  state_t      state_q, state_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  off_q, off_d;
  logic        signed_q, signed_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic [31:0] address_q, address_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_error_q, resp_error_d;

  logic [1:0]  lane_size, lane_off;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, lane_rdata;

  // In IDLE the aligner maps the incoming request; afterwards it works on the latched one.
  assign lane_size = (state_q == IDLE) ? req_size : size_q;
  assign lane_off  = (state_q == IDLE) ? req_addr[1:0] : off_q;

  mem_lane_align u_lane_align (
    .size       (lane_size),
    .offset     (lane_off),
    .sign_ext   (signed_q),
    .wdata      (req_wdata),
    .rdata      (readdata),
    .byteenable (lane_be),
    .writedata  (lane_wdata),
    .rdata_ext  (lane_rdata)
  );

  always_comb begin
    state_d      = state_q;
    size_d       = size_q;
    off_d        = off_q;
    signed_d     = signed_q;
    read_d       = read_q;
    write_d      = write_q;
    address_d    = address_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = 32'h0;
    resp_error_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (is_misaligned(req_size, req_addr[1:0])) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
          end else begin
            state_d   = ACCESS;
            size_d    = req_size;
            off_d     = req_addr[1:0];
            signed_d  = req_signed;
            read_d    = ~req_write;
            write_d   = req_write;
            address_d = {req_addr[31:2], 2'b00};
            be_d      = lane_be;
            wdata_d   = req_write ? lane_wdata : 32'h0;
          end
        end
      end
      ACCESS: begin
        if (!waitrequest) begin
          state_d      = RESP;
          read_d       = 1'b0;
          write_d      = 1'b0;
          resp_valid_d = 1'b1;
          resp_rdata_d = read_q ? lane_rdata : 32'h0;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      size_q       <= SZ_BYTE;
      off_q        <= 2'b00;
      signed_q     <= 1'b0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      address_q    <= 32'h0;
      be_q         <= 4'b0000;
      wdata_q      <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      size_q       <= size_d;
      off_q        <= off_d;
      signed_q     <= signed_d;
      read_q       <= read_d;
      write_q      <= write_d;
      address_q    <= address_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_error_q <= resp_error_d;
    end
  end

  assign req_ready  = (state_q == IDLE) && !reset;
  assign read       = read_q;
  assign write      = write_q;
  assign address    = address_q;
  assign byteenable = be_q;
  assign writedata  = wdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_error = resp_error_q;

endmodule

// File: tb/tb_mem_access_master.sv
// Randomized bench for mem_access_master against an arithmetic reference model
// of lane mapping, extension, alignment rules and cycle timing.
module tb_mem_access_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_error;
  logic [31:0] resp_rdata;
  logic [31:0] address, writedata, readdata;
  logic        read, write, waitrequest;
  logic [3:0]  byteenable;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_access_master dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_error  (resp_error),
    .address     (address),
    .read        (read),
    .write       (write),
    .writedata   (writedata),
    .byteenable  (byteenable),
    .waitrequest (waitrequest),
    .readdata    (readdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: access width in bytes drives alignment, enables and extraction.
  function automatic void model(input bit w, input bit [1:0] sz, input bit sgn,
                                input bit [31:0] addr, input bit [31:0] wd_in,
                                input bit [31:0] rd_in, output bit err,
                                output bit [31:0] be, output bit [31:0] wd,
                                output bit [31:0] rd);
    longint unsigned nbytes, mask, v, ofs;
    nbytes = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
    ofs    = addr % 4;
    err    = (sz == 3) || ((addr % nbytes) != 0);
    be     = 32'(((64'd1 << nbytes) - 1) << ofs);
    mask   = (64'd1 << (8 * nbytes)) - 1;
    if (nbytes == 4)      wd = wd_in;
    else if (nbytes == 2) wd = 32'((wd_in & mask) * 32'h00010001);
    else                  wd = 32'((wd_in & mask) * 32'h01010101);
    v = (rd_in >> (8 * ofs)) & mask;
    if (nbytes < 4 && sgn && v >= (mask + 1) / 2) v = v + 64'h1_0000_0000 - (mask + 1);
    rd = w ? 32'h0 : 32'(v);
  endfunction

  // Issues one request from IDLE and checks every cycle up to and including RESP.
  task automatic run_req(input bit w, input bit [1:0] sz, input bit sgn,
                         input bit [31:0] addr, input bit [31:0] wd_in,
                         input bit [31:0] rd_in, input int waits);
    bit err;
    bit [31:0] be, wd, rd;
    model(w, sz, sgn, addr, wd_in, rd_in, err, be, wd, rd);
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sgn;
    req_addr = addr; req_wdata = wd_in;
    waitrequest = 1'b1; readdata = $urandom;
    @(negedge clk);
    chk("idle_ready", {31'h0, req_ready}, 32'h1);
    chk("idle_resp", {31'h0, resp_valid}, 32'h0);
    chk("idle_strobe", {31'h0, read | write}, 32'h0);
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom);
    req_signed = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    if (err) begin
      @(negedge clk);
      chk("err_valid", {31'h0, resp_valid}, 32'h1);
      chk("err_flag", {31'h0, resp_error}, 32'h1);
      chk("err_rdata", resp_rdata, 32'h0);
      chk("err_strobe", {31'h0, read | write}, 32'h0);
      chk("err_ready", {31'h0, req_ready}, 32'h0);
    end else begin
      for (int k = 0; k <= waits; k++) begin
        waitrequest = (k < waits);
        readdata    = (k < waits) ? $urandom : rd_in;
        @(negedge clk);
        chk("acc_read", {31'h0, read}, {31'h0, !w});
        chk("acc_write", {31'h0, write}, {31'h0, w});
        chk("acc_addr", address, {addr[31:2], 2'b00});
        chk("acc_be", {28'h0, byteenable}, be);
        if (w) chk("acc_wdata", writedata, wd);
        chk("acc_resp", {31'h0, resp_valid}, 32'h0);
        chk("acc_ready", {31'h0, req_ready}, 32'h0);
        @(posedge clk); #1;
      end
      waitrequest = 1'($urandom); readdata = $urandom;
      @(negedge clk);
      chk("resp_valid", {31'h0, resp_valid}, 32'h1);
      chk("resp_error", {31'h0, resp_error}, 32'h0);
      chk("resp_rdata", resp_rdata, rd);
      chk("resp_strobe", {31'h0, read | write}, 32'h0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, rsp;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    waitrequest = 1'b0; readdata = 32'h0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_strobe", {30'h0, read, write}, 32'h0);
    chk("rst_addr", address, 32'h0);
    chk("rst_be", {28'h0, byteenable}, 32'h0);
    chk("rst_wdata", writedata, 32'h0);
    chk("rst_resp", {30'h0, resp_valid, resp_error}, 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_ready", {31'h0, req_ready}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'h0, req_ready}, 32'h1);

    run_req(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 0);
    run_req(1'b0, 2'b00, 1'b1, 32'hBFC0_0003, 32'h0, 32'h8011_2233, 3);
    run_req(1'b0, 2'b00, 1'b0, 32'hBFC0_0003, 32'h0, 32'h8011_2233, 3);
    run_req(1'b1, 2'b01, 1'b0, 32'h0000_0402, 32'h0000_ABCD, 32'h0, 1);
    run_req(1'b0, 2'b01, 1'b1, 32'h0000_0000, 32'h0, 32'h1234_F00D, 0);
    run_req(1'b0, 2'b01, 1'b0, 32'h0000_0001, 32'h0, 32'h0, 0);
    run_req(1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0, 32'h0, 0);
    run_req(1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0, 32'h0, 0);

    // Reset during the second stall cycle of a load.
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b00; req_addr = 32'h100;
    waitrequest = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_read", {31'h0, read}, 32'h1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready", {31'h0, req_ready}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0; waitrequest = 1'b0;
    @(negedge clk);
    chk("rst_mid_drop", {31'h0, read}, 32'h0);
    chk("rst_mid_ready2", {31'h0, req_ready}, 32'h1);
    chk("rst_mid_addr", address, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("rst_mid_noresp", {31'h0, resp_valid}, 32'h0);
      @(negedge clk);
    end

    // Continuous req_valid: one accept per three cycles.
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h20;
    waitrequest = 1'b0; readdata = 32'h5555_AAAA;
    acc = 0; rsp = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (req_valid && req_ready) acc++;
      if (resp_valid) rsp++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("held_accepts", 32'(acc), 32'd4);
    chk("held_resps", 32'(rsp), 32'd4);
    @(negedge clk);
    chk("held_done_ready", {31'h0, req_ready}, 32'h1);

    for (int i = 0; i < 150; i++) begin
      bit [1:0] sz;
      bit [31:0] a;
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
        if (sz == 2'b11) sz = 2'($urandom_range(0, 2)) & ((a[0] | a[1]) ? 2'b00 : 2'b11);
      end
      run_req(1'($urandom), sz, 1'($urandom), a, $urandom, $urandom,
              int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_master.md
# mem_access_master

Avalon-MM initiator that turns MIPS CPU load/store requests into word-aligned bus transactions against the memory slaves. A request carries a byte, halfword or word access at an arbitrary byte address. The block does the following:
- drives `address`, `byteenable` and lane-replicated `writedata`;
- holds the request through `waitrequest` stalls;
- extracts and sign- or zero-extends read data;
- rejects misaligned accesses without touching the bus.

It sits between the CPU datapath and the system memory bus in the testbenches.

## Interface
Parameters:
- (none)

Ports:
- `clk` in 1: single clock; all state changes on rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: CPU request present.
- `req_ready` out 1: request accepted on an edge where `req_valid` and `req_ready` are both 1.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 reserved.
- `req_signed` in 1: sign-extend load result; ignored for word loads and stores.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_error` out 1: misaligned or reserved-size request; qualified by `resp_valid`.
- `address` out 32: `{req_addr[31:2],2'b00}`; no address remapping here.
- `read` out 1: Avalon read strobe.
- `write` out 1: Avalon write strobe.
- `writedata` out 32: lane-replicated store data.
- `byteenable` out 4: lane k = byte offset k; little-endian lanes.
- `waitrequest` in 1: slave stall.
- `readdata` in 32: valid in any cycle where `read`=1 and `waitrequest`=0.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE:
  - `req_ready`=1.
  - On accept with a legal request: latch the request, register the bus outputs, go to ACCESS.
  - On accept with an illegal request: go to RESP with `resp_error`=1; `read`/`write` stay 0.
- Illegal requests:
  - size 11;
  - half with `addr[0]`=1;
  - word with `addr[1:0]`≠0.
- ACCESS:
  - `read` or `write` asserted.
  - `address`, `byteenable` and `writedata` held constant.
  - On an edge with `waitrequest`=0: capture `readdata` (for loads), drop the strobe, go to RESP.
  - While `waitrequest`=1: stay in ACCESS indefinitely; no timeout.
- RESP: `resp_valid`=1 for exactly one cycle, then return to IDLE. `req_ready`=0 in ACCESS and RESP.
- `byteenable`, with a = `addr[1:0]`:
  - byte: `4'b0001<<a`
  - half: `4'b0011<<a`
  - word: `4'b1111`
- `writedata`:
  - byte: `{4{wdata[7:0]}}`
  - half: `{2{wdata[15:0]}}`
  - word: `wdata`
- Load extract:
  - byte: `readdata[8a+:8]`
  - half: `readdata[8a+:16]`
  - Extend to 32 bits per `req_signed`.
  - Word loads pass through unchanged.
- `resp_rdata` and `resp_error` are held stable only during `resp_valid`. Outside RESP they read 0.

## Timing
- Reset values, in force the cycle after a `reset` edge:
  - state IDLE;
  - `read`=`write`=0;
  - `address`=0, `byteenable`=0, `writedata`=0;
  - `resp_valid`=0, `resp_rdata`=0, `resp_error`=0.
- `req_ready` is 0 while `reset` is high and 1 in the first cycle after.
- Accept on edge N. `read`/`write` is high in cycle N+1.
- With zero wait states, the transfer completes at the end of N+1 and `resp_valid` is high in N+2. The next accept is possible at the end of N+3.
- Each wait cycle adds one cycle of latency.
- Misaligned request: `resp_valid` in N+1. No bus cycle is issued.
- Reset mid-ACCESS: the strobe drops the cycle after the reset edge, no `resp_valid` is generated, and the pending request is discarded.
- `req_valid` held high continuously: requests are serviced one at a time. Each is accepted only in IDLE.
- Strobe and `waitrequest` rising in the same cycle: not complete; the bus outputs are held.

## Structure
- Package `mem_access_pkg` contains:
  - `typedef enum logic[1:0] {IDLE, ACCESS, RESP} state_t`;
  - size constants `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`;
  - function `is_misaligned(size, addr)`.
- Sub-module `mem_lane_align` (combinational): size, offset and data in → `byteenable`, replicated `writedata` and extended load data. It is reused by any future unaligned-access logic.
- The top level holds only the FSM and registers.

## Test plan
- Word store to 0x00000010, data 0xDEADBEEF, `waitrequest`=0 → `write`=1 for one cycle with `address`=0x10, `byteenable`=1111, `writedata`=0xDEADBEEF. `resp_valid` 2 cycles after accept, `resp_error`=0.
- Signed byte load from 0xBFC00003, `readdata`=0x80112233, `waitrequest` high for 3 cycles → `read` high for 4 cycles with `address`=0xBFC00000 and `byteenable`=1000 stable; `resp_rdata`=0xFFFFFF80. The same access unsigned gives 0x00000080.
- Half store to 0x00000402, data 0x0000ABCD → `byteenable`=1100, `writedata`=0xABCDABCD.
- Signed half load from 0x00000000, `readdata`=0x1234F00D → `resp_rdata`=0xFFFFF00D.
- Half load from 0x00000001 and word load from 0x00000006 → `resp_valid` with `resp_error`=1 the cycle after accept; `read`/`write` never asserted.
- `reset` asserted during the 2nd `waitrequest` stall cycle → `read`=0 the next cycle, no `resp_valid`, `req_ready`=1 the cycle after `reset` drops.
